// File: rtl/srambank_rmw_ctrl.sv
// Request front-end for a 256x40 synchronous SRAM bank: reads, full writes and
// byte-masked writes (done as read-modify-write), with a registered read response port.
module srambank_rmw_ctrl #(
  parameter int AW = 8,
  parameter int DW = 40,
  parameter int NB = DW / 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_write_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [NB-1:0] req_wmask_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic [AW-1:0] bank_addr_o,
  output logic [DW-1:0] bank_wd_o,
  output logic          bank_sel_o,
  output logic          bank_read_o,
  output logic          bank_write_o,
  input  logic [DW-1:0] bank_dataout_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, RD_DATA, RMW_WR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NB-1:0] mask_q, mask_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DW-1:0] merged;
  logic          accept;
  logic          bank_read, bank_write;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wd;

  // Merge the latched write bytes over the word just read back from the bank.
  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign merged[8*gi +: 8] = mask_q[gi] ? wdata_q[8*gi +: 8] : bank_dataout_i[8*gi +: 8];
  end

  assign req_ready_o = (state_q == IDLE) & (~rsp_valid_q | rsp_ready_i);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    bank_read  = 1'b0;
    bank_write = 1'b0;
    bank_addr  = '0;
    bank_wd    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!req_write_i) begin
            bank_read = 1'b1;
            bank_addr = req_addr_i;
            state_d   = RD_DATA;
          end else if (&req_wmask_i) begin
            bank_write = 1'b1;
            bank_addr  = req_addr_i;
            bank_wd    = req_wdata_i;
          end else if (|req_wmask_i) begin
            bank_read = 1'b1;
            bank_addr = req_addr_i;
            addr_d    = req_addr_i;
            wdata_d   = req_wdata_i;
            mask_d    = req_wmask_i;
            state_d   = RMW_WR;
          end
        end
      end
      RD_DATA: state_d = IDLE;
      RMW_WR: begin
        bank_write = 1'b1;
        bank_addr  = addr_q;
        bank_wd    = merged;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response register: a fresh read result takes priority over a handshake clear.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
    if (state_q == RD_DATA) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = bank_dataout_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Reset forces the bank pins quiet so an in-flight RMW write is dropped.
  assign bank_read_o  = bank_read & ~reset_i;
  assign bank_write_o = bank_write & ~reset_i;
  assign bank_addr_o  = reset_i ? '0 : bank_addr;
  assign bank_wd_o    = reset_i ? '0 : bank_wd;
  assign bank_sel_o   = bank_read_o | bank_write_o;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_srambank_rmw_ctrl.sv
// Randomized scoreboard bench for srambank_rmw_ctrl with a behavioural SRAM bank
// and a word-level reference memory.
module tb_srambank_rmw_ctrl;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0, req_write_i = 1'b0, rsp_ready_i = 1'b1;
  logic [7:0]  req_addr_i = '0;
  logic [39:0] req_wdata_i = '0;
  logic [4:0]  req_wmask_i = '0;
  logic        req_ready_o, rsp_valid_o, bank_sel_o, bank_read_o, bank_write_o, busy_o;
  logic [39:0] rsp_rdata_o, bank_wd_o;
  logic [7:0]  bank_addr_o;
  logic [39:0] bank_dataout_i;

  srambank_rmw_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .bank_addr_o(bank_addr_o), .bank_wd_o(bank_wd_o), .bank_sel_o(bank_sel_o),
    .bank_read_o(bank_read_o), .bank_write_o(bank_write_o),
    .bank_dataout_i(bank_dataout_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural SRAM bank: latched output updates only on a selected read.
  logic [39:0] bank_mem [256];
  logic [39:0] bank_dout = '0;
  assign bank_dataout_i = bank_dout;
  always @(posedge clk_i) begin
    if (bank_sel_o && bank_write_o) bank_mem[bank_addr_o] <= bank_wd_o;
    if (bank_sel_o && bank_read_o) bank_dout <= bank_mem[bank_addr_o];
  end

  logic [39:0] ref_mem [256];
  typedef struct { logic [39:0] data; int cyc; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0, cyc = 0;
  bit rand_rdy = 1'b0, seen = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] byte_mask(input logic [4:0] m);
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Drive one request, wait (bounded) for acceptance, and update the reference model.
  task automatic issue(input bit w, input logic [7:0] a, input logic [39:0] d,
                       input logic [4:0] m, input bit commit, output int acc_cyc);
    int n = 0;
    exp_t e;
    req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = d; req_wmask_i = m;
    acc_cyc = -1;
    forever begin
      @(negedge clk_i);
      if (req_ready_o) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (n <= 200) begin
      acc_cyc = cyc;
      if (!w) begin
        e.data = ref_mem[a]; e.cyc = cyc + 2;
        exp_q.push_back(e);
      end else if (commit) begin
        ref_mem[a] = (ref_mem[a] & ~byte_mask(m)) | (d & byte_mask(m));
      end
      $display("req %s addr=0x%02h data=0x%010h mask=%05b acc_cyc=%0d",
               w ? "WR" : "RD", a, d, m, cyc);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  // Monitor: compares responses against the scoreboard, independent of stimulus.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        if (bank_read_o && bank_write_o) chk("rd_wr_overlap", 64'd1, 64'd0);
        if (bank_sel_o !== (bank_read_o | bank_write_o)) chk("bank_sel", {63'd0, bank_sel_o}, {63'd0, bank_read_o | bank_write_o});
        if (rsp_valid_o && !seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
          else chk("rsp_latency", 64'(cyc), 64'(exp_q[0].cyc));
        end
        if (rsp_valid_o && rsp_ready_i) begin
          seen = 1'b0;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_data", {24'd0, rsp_rdata_o}, {24'd0, e.data});
            $display("rsp data=0x%010h expected=0x%010h", rsp_rdata_o, e.data);
          end
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (rand_rdy) rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int ac, c0;
    logic [39:0] held;
    logic [4:0] m;
    for (int i = 0; i < 256; i++) begin
      bank_mem[i] = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
      ref_mem[i] = bank_mem[i];
    end

    // Reset state
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_bank_sel", {63'd0, bank_sel_o}, 64'd0);
      chk("rst_bank_wd", {24'd0, bank_wd_o}, 64'd0);
    end
    @(posedge clk_i); #1; reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata_o}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
    @(posedge clk_i); #1;

    // Full write then read of address 0
    issue(1, 8'h00, 40'h12_3456_789A, 5'h1F, 1, ac);
    issue(0, 8'h00, 40'h0, 5'h0, 1, ac);

    // Partial write merge and one-cycle stall
    issue(1, 8'h10, 40'hAA_AAAA_AAAA, 5'h1F, 1, ac);
    issue(1, 8'h10, 40'h55_5555_5555, 5'b00101, 1, ac);
    @(negedge clk_i);
    chk("rmw_ready_low", {63'd0, req_ready_o}, 64'd0);
    chk("rmw_bank_write", {63'd0, bank_write_o}, 64'd1);
    chk("rmw_bank_wd", {24'd0, bank_wd_o}, 64'h00AA_AA55_AA55);
    @(negedge clk_i);
    chk("rmw_ready_back", {63'd0, req_ready_o}, 64'd1);
    @(posedge clk_i); #1;
    issue(0, 8'h10, 40'h0, 5'h0, 1, ac);
    repeat (3) @(posedge clk_i);
    #1;

    // Held response with backpressure, then read accepted on the releasing cycle
    rsp_ready_i = 1'b0;
    issue(0, 8'h20, 40'h0, 5'h0, 1, ac);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("stall_valid_on", {63'd0, rsp_valid_o}, 64'd1);
    held = rsp_rdata_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_valid", {63'd0, rsp_valid_o}, 64'd1);
      chk("stall_data", {24'd0, rsp_rdata_o}, {24'd0, held});
      chk("stall_ready_low", {63'd0, req_ready_o}, 64'd0);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    c0 = cyc;
    issue(0, 8'h21, 40'h0, 5'h0, 1, ac);
    chk("release_accept", 64'(ac), 64'(c0));

    // Back-to-back full writes at the top of the address space
    issue(1, 8'hFD, 40'hFD_0000_00FD, 5'h1F, 1, ac);
    c0 = ac;
    issue(1, 8'hFE, 40'hFE_0000_00FE, 5'h1F, 1, ac);
    chk("b2b_wr1", 64'(ac), 64'(c0 + 1));
    issue(1, 8'hFF, 40'hFF_0000_00FF, 5'h1F, 1, ac);
    chk("b2b_wr2", 64'(ac), 64'(c0 + 2));
    issue(0, 8'hFD, 40'h0, 5'h0, 1, ac);
    issue(0, 8'hFE, 40'h0, 5'h0, 1, ac);
    issue(0, 8'hFF, 40'h0, 5'h0, 1, ac);
    issue(0, 8'h00, 40'h0, 5'h0, 1, ac);

    // Zero-mask write: accepted with no bank access
    issue(1, 8'h30, 40'h01_0203_0405, 5'h1F, 1, ac);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 8'h30;
    req_wdata_i = 40'hFF_FFFF_FFFF; req_wmask_i = 5'h00;
    @(negedge clk_i);
    chk("zmask_ready", {63'd0, req_ready_o}, 64'd1);
    chk("zmask_no_sel", {63'd0, bank_sel_o}, 64'd0);
    @(posedge clk_i); #1; req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("zmask_idle", {63'd0, busy_o}, 64'd0);
    @(posedge clk_i); #1;
    issue(0, 8'h30, 40'h0, 5'h0, 1, ac);
    repeat (3) @(posedge clk_i);
    #1;

    // Reset during RMW_WR suppresses the write
    issue(1, 8'h40, 40'h11_2233_4455, 5'h1F, 1, ac);
    issue(1, 8'h40, 40'hEE_EEEE_EEEE, 5'b11010, 0, ac);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("rst_rmw_no_write", {63'd0, bank_write_o}, 64'd0);
    @(posedge clk_i); #1; reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_rmw_idle", {63'd0, busy_o}, 64'd0);
    chk("rst_rmw_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    @(posedge clk_i); #1;
    issue(0, 8'h40, 40'h0, 5'h0, 1, ac);
    repeat (3) @(posedge clk_i);
    #1;

    // Reset during RD_DATA drops the response
    issue(0, 8'h41, 40'h0, 5'h0, 1, ac);
    reset_i = 1'b1;
    @(posedge clk_i); #1; reset_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    chk("rst_rd_drop", {63'd0, rsp_valid_o}, 64'd0);
    repeat (2) @(negedge clk_i);
    chk("rst_rd_still_off", {63'd0, rsp_valid_o}, 64'd0);
    @(posedge clk_i); #1;

    // Random mix with random backpressure over a small address window
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: m = 5'h1F;
        1: m = 5'h00;
        default: m = 5'($urandom_range(1, 30));
      endcase
      issue($urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)) + 8'h80,
            {$urandom, $urandom} & 40'hFF_FFFF_FFFF, m, 1, ac);
    end
    rand_rdy = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
